// File: rtl/cskipa_pipe_adder.sv
// ---------------------------------------------------------------------------
// cskipa_pipe_adder
//   Pipelined carry-skip adder. The operands are split into NBLK = WIDTH/BLK_W
//   blocks. Pipeline stage k adds block k, using the carry registered by
//   stage k-1 (stage 0 uses i_cin). Each block's carry-out is taken from the
//   skip path when the whole block propagates, and from the ripple chain
//   otherwise. Operand bits not yet added and sum bits already computed
//   travel with the beat. The last stage is the output register.
//   A single global enable (en = !o_valid || i_ready) advances or holds the
//   whole pipeline, so bubbles stay in place and beat order is kept.
//
// Parameters
//   WIDTH  operand/sum width, must be >= 2
//   BLK_W  carry-skip block width, must divide WIDTH exactly
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_valid      operand beat offered
//   o_ready      beat accepted this cycle when i_valid is high (equals en)
//   i_add_term1  first addend
//   i_add_term2  second addend
//   i_cin        carry-in
//   o_valid      result beat present
//   i_ready      downstream accepts the result
//   o_ovf        signed overflow of the beat (only with CSKIPA_OVF_EN)
//   sum          registered sum
//   cout         registered carry-out of bit WIDTH-1
//
// Configuration
//   CSKIPA_OVF_EN  define to add the o_ovf port and its logic
// ---------------------------------------------------------------------------
module cskipa_pipe_adder #(
    parameter int WIDTH = 8,
    parameter int BLK_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
`ifdef CSKIPA_OVF_EN
    output logic             o_ovf,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NBLK = WIDTH / BLK_W;

    // One beat in flight: operands, partial sum and the carry into the next block.
    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
    } beat_t;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
    } blk_res_t;

    // Adds block k of a/b into s. The carry-out takes the skip path when
    // every bit of the block propagates.
    function automatic blk_res_t blk_add(input int k,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic [WIDTH-1:0] s,
                                         input logic c_in);
        blk_res_t r;
        logic     carry;
        logic     prop;
        logic     x;
        int       idx;
        r.s   = s;
        carry = c_in;
        prop  = 1'b1;
        for (int j = 0; j < BLK_W; j++) begin
            idx      = k * BLK_W + j;
            x        = a[idx] ^ b[idx];
            r.s[idx] = x ^ carry;
            carry    = (a[idx] & b[idx]) | (x & carry);
            prop     = prop & x;
        end
        r.c = prop ? c_in : carry;
        return r;
    endfunction

    logic     en;
    beat_t    in_beat;
    beat_t    last_src;
    blk_res_t res_last;

    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    always_comb begin
        in_beat.vld = i_valid;
        in_beat.a   = i_add_term1;
        in_beat.b   = i_add_term2;
        in_beat.s   = '0;
        in_beat.c   = i_cin;
    end

    // Intermediate stages 0 .. NBLK-2; absent when there is a single block.
    if (NBLK > 1) begin : g_pipe
        beat_t    pipe_q [NBLK-1];
        beat_t    pipe_d [NBLK-1];
        blk_res_t res;

        always_comb begin
            // NOTE: every variable gets a value on every pass through the
            // block, so no latch is inferred.
            res          = blk_add(0, in_beat.a, in_beat.b, in_beat.s, in_beat.c);
            pipe_d[0]    = in_beat;
            pipe_d[0].s  = res.s;
            pipe_d[0].c  = res.c;
            for (int k = 1; k < NBLK - 1; k++) begin
                res         = blk_add(k, pipe_q[k-1].a, pipe_q[k-1].b,
                                      pipe_q[k-1].s, pipe_q[k-1].c);
                pipe_d[k]   = pipe_q[k-1];
                pipe_d[k].s = res.s;
                pipe_d[k].c = res.c;
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                // NOTE: only the valid bits are reset; the data fields are
                // ignored while their stage is invalid.
                for (int k = 0; k < NBLK - 1; k++) begin
                    pipe_q[k].vld <= 1'b0;
                end
            end else if (en) begin
                pipe_q <= pipe_d;
            end
        end

        always_comb last_src = pipe_q[NBLK-2];
    end else begin : g_single
        always_comb last_src = in_beat;
    end

`ifdef CSKIPA_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        en        = !o_valid_q || i_ready;
        res_last  = blk_add(NBLK - 1, last_src.a, last_src.b, last_src.s, last_src.c);
        o_valid_d = last_src.vld;
        sum_d     = res_last.s;
        cout_d    = res_last.c;
`ifdef CSKIPA_OVF_EN
        // a^b^s at the MSB recovers the carry into bit WIDTH-1.
        ovf_d     = last_src.a[WIDTH-1] ^ last_src.b[WIDTH-1]
                  ^ res_last.s[WIDTH-1] ^ res_last.c;
`endif
    end

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            o_valid_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
`ifdef CSKIPA_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else if (en) begin
            o_valid_q <= o_valid_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
`ifdef CSKIPA_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign o_ready = en;
    assign o_valid = o_valid_q;
    assign sum     = sum_q;
    assign cout    = cout_q;
`ifdef CSKIPA_OVF_EN
    assign o_ovf   = ovf_q;
`endif

endmodule

// File: doc/cskipa_pipe_adder.md
CSKIPA_PIPE_ADDER -- requirements
Module: cskipa_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits; SHALL be >= 2.
REQ-002 Parameter BLK_W, default 4: carry-skip block width; SHALL divide WIDTH exactly. NBLK = WIDTH/BLK_W.
REQ-003 i_clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 i_rst  input  1  reset; synchronous, active-high.
REQ-005 i_valid  input  1  operand beat offered.
REQ-006 o_ready  output  1  block can accept a beat this cycle.
REQ-007 i_add_term1  input  WIDTH  first addend, unsigned (two's complement when overflow is enabled).
REQ-008 i_add_term2  input  WIDTH  second addend.
REQ-009 i_cin  input  1  carry-in.
REQ-010 o_valid  output  1  result beat present.
REQ-011 i_ready  input  1  downstream accepts result.
REQ-012 sum  output  WIDTH  registered sum.
REQ-013 cout  output  1  registered carry-out of bit WIDTH-1.
REQ-014 o_ovf  output  1  signed overflow; present only under CSKIPA_OVF_EN.

Function
REQ-015 Accept SHALL occur when i_valid && o_ready; transfer SHALL occur when o_valid && i_ready.
REQ-016 Pipeline: NBLK stages; stage k SHALL add block k (bits k*BLK_W .. k*BLK_W+BLK_W-1) using the carry registered by stage k-1 (stage 0 uses i_cin).
REQ-017 Each stage SHALL compute block propagate P = AND of (a XOR b) over the block; carry-out = P ? carry-in : ripple carry-out (skip path).
REQ-018 Unprocessed upper operand bits and completed lower sum bits SHALL travel with the beat through stage registers.
REQ-019 Latency SHALL be exactly NBLK cycles from accept to o_valid when not stalled.
REQ-020 Global advance enable en = !o_valid || i_ready; o_ready SHALL equal en; all stages hold when en = 0.
REQ-021 Throughput SHALL be one beat per cycle while en = 1; bubbles (accept cycles with i_valid = 0) propagate as invalid stages and are not collapsed.
REQ-022 Result SHALL equal {cout, sum} = i_add_term1 + i_add_term2 + i_cin, modulo 2^(WIDTH+1), for every beat.
REQ-023 sum, cout, o_ovf SHALL be stable while o_valid && !i_ready.
REQ-024 Beat order SHALL be preserved; no beat SHALL be dropped or duplicated.
REQ-025 Simultaneous accept and transfer in one cycle SHALL be legal and lose no data.
REQ-026 When NBLK = 1 the block SHALL be a single registered stage with latency 1.

Reset
REQ-027 While i_rst = 1 at a clock edge: all stage valid bits, o_valid, sum, cout, o_ovf SHALL become 0.
REQ-028 o_ready SHALL read 1 in the first cycle after reset deasserts.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; no result from a pre-reset beat SHALL appear.
REQ-030 Inputs offered during reset SHALL NOT be accepted.

Configuration
REQ-031 Macro CSKIPA_OVF_EN defined: o_ovf port exists; o_ovf = carry into bit WIDTH-1 XOR cout, registered with the beat, valid with o_valid.
REQ-032 CSKIPA_OVF_EN undefined: o_ovf port and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8, BLK_W=4, latency 2)
REQ-033 Skip path: a=0xFF, b=0x01, cin=0, i_ready=1 -> two cycles later o_valid=1, sum=0x00, cout=1.
REQ-034 Full skip: a=0x0F, b=0xF0, cin=1 -> sum=0x00, cout=1; with cin=0 -> sum=0xFF, cout=0.
REQ-035 Back-to-back: 0x12+0x34, 0x80+0x80, 0xAA+0x55 cin=1 on consecutive cycles -> sums 0x46/c0, 0x00/c1, 0x00/c1 on three consecutive cycles.
REQ-036 Backpressure: i_ready=0 for 5 cycles with pipeline full -> o_ready=0, sum/cout held; i_ready=1 -> beats drain in order, none lost.
REQ-037 Reset mid-flight: accept 0x01+0x01, assert i_rst next cycle -> o_valid stays 0; no 0x02 ever emitted.
REQ-038 With CSKIPA_OVF_EN: 0x7F+0x01 -> sum=0x80, o_ovf=1; 0xFF+0x01 -> o_ovf=0, cout=1.
